// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC computing cos(angle) in signed Q2.20 with a level clk_en/done handshake.
// Optional macro CORDIC_SIN_OUT_EN adds a registered sin_out port loaded from the final y.
module cordic_cos_iter #(
  parameter int unsigned WIDTH      = 22,
  parameter int unsigned ITERATIONS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] cos_out,
`ifdef CORDIC_SIN_OUT_EN
  output logic signed [WIDTH-1:0] sin_out,
`endif
  output logic                    done
);

  localparam int unsigned IW   = WIDTH + 2;
  localparam int unsigned CntW = 5;
  localparam logic signed [IW-1:0] KVal = IW'(636751);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CntW-1:0]        iter_q, iter_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic                   done_q, done_d;
`ifdef CORDIC_SIN_OUT_EN
  logic signed [WIDTH-1:0] sin_q, sin_d;
`endif

  logic signed [IW-1:0] x_sh, y_sh, atan_i;

  // round(atan(2^-i) * 2^20)
  function automatic logic signed [IW-1:0] atan_rom(input logic [CntW-1:0] i);
    int val;
    case (i)
      5'd0:    val = 823550;
      5'd1:    val = 486170;
      5'd2:    val = 256879;
      5'd3:    val = 130396;
      5'd4:    val = 65451;
      5'd5:    val = 32757;
      5'd6:    val = 16383;
      5'd7:    val = 8192;
      5'd8:    val = 4096;
      5'd9:    val = 2048;
      5'd10:   val = 1024;
      5'd11:   val = 512;
      5'd12:   val = 256;
      5'd13:   val = 128;
      5'd14:   val = 64;
      5'd15:   val = 32;
      5'd16:   val = 16;
      5'd17:   val = 8;
      5'd18:   val = 4;
      5'd19:   val = 2;
      default: val = 0;
    endcase
    return IW'(val);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    logic [2:0] top;
    top = v[IW-1:WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return v[WIDTH-1:0];
    else if (v[IW-1])                   return {1'b1, {(WIDTH-1){1'b0}}};
    else                                return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_i = atan_rom(iter_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    cos_d   = cos_q;
    done_d  = done_q;
`ifdef CORDIC_SIN_OUT_EN
    sin_d   = sin_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (clk_en) begin
          x_d     = KVal;
          y_d     = '0;
          z_d     = {{2{angle[WIDTH-1]}}, angle};
          iter_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!clk_en) begin
          state_d = StIdle;
        end else begin
          if (!z_q[IW-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end
          iter_d = iter_q + 1'b1;
          if (iter_q == CntW'(ITERATIONS - 1)) begin
            cos_d   = sat(x_d);
`ifdef CORDIC_SIN_OUT_EN
            sin_d   = sat(y_d);
`endif
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!clk_en) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      cos_q   <= '0;
      done_q  <= 1'b0;
`ifdef CORDIC_SIN_OUT_EN
      sin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      cos_q   <= cos_d;
      done_q  <= done_d;
`ifdef CORDIC_SIN_OUT_EN
      sin_q   <= sin_d;
`endif
    end
  end

  assign cos_out = cos_q;
  assign done    = done_q;
`ifdef CORDIC_SIN_OUT_EN
  assign sin_out = sin_q;
`endif

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Self-checking bench for cordic_cos_iter: a transaction-level cos/latency model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_cordic_cos_iter;

  localparam int W    = 22;
  localparam int ITER = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, clk_en, clk_en8;
  logic signed [W-1:0] angle;
  logic signed [W-1:0] cos_out, cos8;
  logic                done, done8;
`ifdef CORDIC_SIN_OUT_EN
  logic signed [W-1:0] sin_out, sin8;
`endif

  cordic_cos_iter #(.WIDTH(W), .ITERATIONS(ITER)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .angle   (angle),
    .cos_out (cos_out),
`ifdef CORDIC_SIN_OUT_EN
    .sin_out (sin_out),
`endif
    .done    (done)
  );

  cordic_cos_iter #(.WIDTH(W), .ITERATIONS(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en8),
    .angle   (angle),
    .cos_out (cos8),
`ifdef CORDIC_SIN_OUT_EN
    .sin_out (sin8),
`endif
    .done    (done8)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
  endtask

  // Transaction-level model: accepted angle, cycles elapsed, ideal cos/sin on completion.
  bit  m_busy, m_done;
  int  m_cnt, m_cos, m_sin, m_tol;
  real m_ang;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cos  <= 0;
      m_sin  <= 0;
      m_tol  <= 0;
    end else if (m_done) begin
      if (!clk_en) m_done <= 1'b0;
    end else if (m_busy) begin
      if (!clk_en) begin
        m_busy <= 1'b0;
      end else if (m_cnt + 1 == ITER) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_cos  <= int'($cos(m_ang) * 1048576.0);
        m_sin  <= int'($sin(m_ang) * 1048576.0);
        m_tol  <= 64;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (clk_en) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_ang  <= real'(angle) / 1048576.0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_done", int'(done), int'(m_done), 0);
      check("model_cos", int'(cos_out), m_cos, m_tol);
`ifdef CORDIC_SIN_OUT_EN
      check("model_sin", int'(sin_out), m_sin, m_tol);
`endif
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1 || lat >= 40) break;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1, 0);
  endtask

  task automatic request(input logic signed [W-1:0] a, input int exp_cos, input string nm);
    int lat;
    angle  = a;
    clk_en = 1'b1;
    wait_done(lat);
    check({nm, "_latency"}, lat, 17, 0);
    check({nm, "_cos"}, int'(cos_out), exp_cos, 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    reset_n = 1'b0;
    clk_en  = 1'b0;
    clk_en8 = 1'b0;
    angle   = '0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    checking = 1'b1;
    check("reset_cos", int'(cos_out), 0, 0);
    check("reset_done", int'(done), 0, 0);

    // angle 0, then hold clk_en with done high
    request(22'sd0, 1048576, "zero");
`ifdef CORDIC_SIN_OUT_EN
    check("zero_sin", int'(sin_out), 0, 64);
`endif
    repeat (3) @(negedge clk);
    check("hold_done", int'(done), 1, 0);
    check("hold_cos", int'(cos_out), 1048576, 64);
    clk_en = 1'b0;
    @(negedge clk);

    request(22'sd1048576, 566548, "pos1");
`ifdef CORDIC_SIN_OUT_EN
    check("pos1_sin", int'(sin_out), 882347, 64);
`endif
    clk_en = 1'b0;
    @(negedge clk);
    request(22'sh300000, 566548, "neg1");
`ifdef CORDIC_SIN_OUT_EN
    check("neg1_sin", int'(sin_out), -882347, 64);
`endif
    clk_en = 1'b0;
    @(negedge clk);

    request(22'sd524288, 920211, "half");
    clk_en = 1'b0;
    @(negedge clk);
    check("drop_done", int'(done), 0, 0);
    check("drop_cos", int'(cos_out), 920211, 64);

    // abort at RUN cycle 5
    angle  = 22'sd1048576;
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    clk_en = 1'b0;
    seen   = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 0, 0);
    check("abort_cos_held", int'(cos_out), 920211, 64);
    request(22'sd0, 1048576, "after_abort");

    // reset mid-run at RUN cycle 10, clk_en held
    clk_en = 1'b0;
    @(negedge clk);
    angle  = 22'sd524288;
    clk_en = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_done", int'(done), 0, 0);
    check("midrst_cos", int'(cos_out), 0, 0);
    reset_n = 1'b1;
    wait_done(lat);
    check("midrst_latency", lat, 17, 0);
    check("midrst_cos_final", int'(cos_out), 920211, 64);

    // back-to-back with a single idle edge
    clk_en = 1'b0;
    @(negedge clk);
    check("b2b_gap_done", int'(done), 0, 0);
    request(22'sd1048576, 566548, "b2b");
    clk_en = 1'b0;
    @(negedge clk);

    // 8-iteration instance: latency 9, coarse accuracy
    angle   = 22'sd1048576;
    clk_en8 = 1'b1;
    lat     = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done8 === 1'b1 || lat >= 40) break;
    end
    check("it8_latency", lat, 9, 0);
    check("it8_cos", int'(cos8), 566548, 12000);
    clk_en8 = 1'b0;
    repeat (2) @(negedge clk);
    check("it8_drop_done", int'(done8), 0, 0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_cos_iter.md
Name: cordic_cos_iter

Overview:
- Iterative rotation-mode CORDIC that computes cos(angle) for the Task 7 datapath.
- Sits between Float_Fixed_Conversion (upstream) and Fixed_Float_Conversion (downstream).
- Consumes a signed fixed-point angle in radians and produces a signed fixed-point cosine.
- Uses the same level-enable/done handshake as the other datapath stages.

Parameters:
- WIDTH, 22: angle/cos word width. Signed Q2.20: 1 sign bit, 1 integer bit, 20 fraction bits.
- ITERATIONS, 16: number of micro-rotations. Legal range 8..20.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- clk_en  input  1  level request. Held high by upstream until done is seen.
- angle  input  WIDTH  signed Q2.20 radians. Sampled only on acceptance.
- cos_out  output  WIDTH  signed Q2.20 cosine. Registered.
- done  output  1  result valid. Registered.

Behaviour:
- Reset: sampled only at posedge clk with reset_n=0; overrides everything, including mid-operation. State=IDLE, cos_out=0, done=0, x/y/z/iteration counter=0.
- States are IDLE, RUN, DONE.
- IDLE:
  - On an edge with clk_en=1: latch x=K, y=0, z=angle, iter=0; go to RUN.
  - K = round(0.607252935*2^20) = 636751.
  - On an edge with clk_en=0: stay in IDLE.
- RUN, one micro-rotation per edge for i = 0..ITERATIONS-1:
  - d=+1 if z>=0 (sign bit clear), else d=-1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*ATAN[i].
  - Shifts are arithmetic. All three updates use the pre-edge values.
  - ATAN[i] = round(atan(2^-i)*2^20), held in a 20-entry constant ROM; ATAN[0]=823550.
  - Internal x/y/z are WIDTH+2 bits. cos_out is x saturated to the WIDTH signed range.
  - On the edge performing i=ITERATIONS-1: cos_out <= final x (saturated), done <= 1, state=DONE.
  - clk_en=0 seen on any RUN edge: abort to IDLE; done stays 0, cos_out unchanged.
- DONE:
  - cos_out and done hold while clk_en=1.
  - First edge with clk_en=0: done <= 0, state=IDLE. cos_out keeps its last value.
- Latency: the acceptance edge is E0. done is high after edge E(ITERATIONS), i.e. ITERATIONS+1 cycles after clk_en is sampled high. Default is 17 cycles.
- New requests:
  - A new request needs at least one clk_en=0 edge; there is no restart from DONE.
  - angle changes after acceptance are ignored.
  - clk_en 0→1 on the cycle directly after DONE→IDLE is accepted normally.
- Range:
  - Accuracy is guaranteed for |angle| <= 1.0 rad, the upstream (x-128)/128 range.
  - Inputs within ±1.7433 rad converge with reduced accuracy.
  - Beyond that, output is unspecified but must not overflow the WIDTH+2-bit internal registers.
- Accuracy: for ITERATIONS=16, |cos_out - round(cos(angle)*2^20)| <= 64 LSB.

Optional Feature:
- Macro: CORDIC_SIN_OUT_EN.
- Defined:
  - Adds output port sin_out, WIDTH bits, signed Q2.20.
  - Loaded from final y (saturated) on the same edge as cos_out.
  - Same reset (0), hold and abort rules as cos_out.
- Undefined: port and logic are absent; cos_out behaviour and timing are identical.

Test Plan:
- Reset, then angle=0 with clk_en held high:
  - done rises exactly 17 cycles after acceptance; cos_out=1048576±64.
  - If CORDIC_SIN_OUT_EN: sin_out=0±64.
- angle=1048576 (1.0 rad): cos_out=566548±64. Then angle=0x300000 (-1.0 rad): cos_out=566548±64.
  - If CORDIC_SIN_OUT_EN: sin_out=882347±64 and -882347±64 respectively.
- angle=524288 (0.5 rad): cos_out=920211±64.
  - Drop clk_en one cycle after done: done=0 next edge, cos_out holds 920211.
- Drop clk_en at RUN cycle 5:
  - Block returns to IDLE and done never asserts.
  - A new request with angle=0 then completes with the normal 17-cycle latency.
- reset_n=0 for one edge at RUN cycle 10: next cycle done=0, cos_out=0, state IDLE. Held clk_en restarts a full conversion after reset_n returns high.
- Back-to-back:
  - Drop clk_en for exactly one edge after done, then reassert with angle=1048576.
  - Second result is 566548±64; the first result is not reissued.
  - Repeat with ITERATIONS=8 and check latency of 9 cycles.
